dt_mem_resp: RTL
================

DT_MEM_RESP -- requirements
Module: dt_mem_resp

Interface
REQ-001 The block SHALL have parameter STI_DEPTH, default 1024, meaning the number of 16-bit source words.
REQ-002 The block SHALL have parameter RES_DEPTH, default 16384, meaning the number of 8-bit result bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ld_valid, input, 1 bit: a load pixel is offered.
REQ-006 The block SHALL have port ld_pix, input, 1 bit: the binary pixel value.
REQ-007 The block SHALL have port ld_ready, output, 1 bit: the block accepts a pixel.
REQ-008 The block SHALL have port ld_done, output, 1 bit: the image is loaded and the block is serving.
REQ-009 The block SHALL have port sti_rd, input, 1 bit: source read strobe.
REQ-010 The block SHALL have port sti_addr, input, 10 bits: source word address.
REQ-011 The block SHALL have port sti_di, output, 16 bits: source read data.
REQ-012 The block SHALL have port res_rd, input, 1 bit: result read strobe.
REQ-013 The block SHALL have port res_wr, input, 1 bit: result write strobe.
REQ-014 The block SHALL have port res_addr, input, 14 bits: result byte address.
REQ-015 The block SHALL have port res_do, input, 8 bits: result write data.
REQ-016 The block SHALL have port res_di, output, 8 bits: result read data.
REQ-017 The block SHALL have port done, input, 1 bit: the client has finished.
REQ-018 The block SHALL have port dump_valid, output, 1 bit: dump byte valid.
REQ-019 The block SHALL have port dump_data, output, 8 bits: dump byte.
REQ-020 The block SHALL have port dump_last, output, 1 bit: the final dump byte.
REQ-021 The block SHALL have port dump_ready, input, 1 bit: dump sink ready.
REQ-022 The block SHALL have port err, output, 1 bit: sticky protocol error.

Function
REQ-023 The FSM SHALL have states LOAD, SERVE, DUMP and FIN, with LOAD entered on reset.
REQ-024 In LOAD, ld_ready SHALL be 1, and each pixel accepted (ld_valid&ld_ready) SHALL be packed MSB-first: pixel k goes to word k/16, bit 15-(k%16).
REQ-025 A word SHALL be written to sti memory on the cycle its 16th pixel is accepted.
REQ-026 After pixel STI_DEPTH*16-1 is accepted, the FSM SHALL go to SERVE on the next edge; ld_ready SHALL drop to 0 and ld_done SHALL rise to 1 in the same cycle.
REQ-027 In SERVE, sti_rd high at edge N SHALL present mem[sti_addr] on sti_di after edge N; sti_di SHALL hold its value when sti_rd is low.
REQ-028 In SERVE, res_wr high at an edge SHALL write res_do to res_addr at that edge.
REQ-029 In SERVE, res_rd high at edge N SHALL present mem[res_addr] on res_di after edge N (1-cycle latency).
REQ-030 When res_rd and res_wr are both high, res_di SHALL return the newly written res_do (write-first).
REQ-031 Accesses on the sti and res ports outside SERVE SHALL be ignored: no write, and the outputs hold.
REQ-032 done sampled high in SERVE SHALL move the FSM to DUMP on the next edge; done SHALL be ignored in all other states.
REQ-033 DUMP SHALL stream res[0..RES_DEPTH-1] in ascending order, one byte per cycle where dump_valid&dump_ready.
REQ-034 While dump_valid=1 and dump_ready=0, dump_data and dump_last SHALL be held stable.
REQ-035 dump_last SHALL be 1 only with byte RES_DEPTH-1; after that byte's handshake the FSM SHALL go to FIN.
REQ-036 FIN SHALL be terminal until reset, with dump_valid=0.
REQ-037 Result bytes never written SHALL dump as 8'h00.

Reset
REQ-038 On reset assertion, state=LOAD and the pixel counter and dump counter SHALL clear immediately, including mid-load or mid-dump.
REQ-039 On reset, ld_ready=1, ld_done=0, sti_di=0, res_di=0, dump_valid=0, dump_data=0, dump_last=0 and err=0.
REQ-040 On reset, a valid-map SHALL mark all result bytes unwritten; memory array contents SHALL NOT be cleared.

Configuration
REQ-041 The feature SHALL be controlled by macro DT_MEM_ERR_CHECK_EN.
REQ-042 With DT_MEM_ERR_CHECK_EN defined, err SHALL set and stay set until reset on any of the following:
- sti_rd, res_rd or res_wr high outside SERVE;
- ld_valid high outside LOAD;
- done high while in LOAD.
REQ-043 Without DT_MEM_ERR_CHECK_EN, err SHALL be a constant 0 and no checking logic SHALL exist.

Verification
REQ-044 Load 16 pixels 1,0,0,...,0,1 then read sti_addr 0 in SERVE -> sti_di=16'h8001 one cycle after sti_rd.
REQ-045 Write res_addr 14'h0005 with res_do 8'h2A while also reading it -> res_di=8'h2A next cycle; a later read of 14'h0006 -> 8'h00.
REQ-046 Full load of 16384 pixels with ld_valid toggling every other cycle -> ld_done rises exactly one cycle after the last accepted pixel.
REQ-047 done pulse, then dump_ready low for 3 cycles at byte 5 -> dump_data stable through the stall; 16384 bytes total; dump_last only on the last byte; then FIN.
REQ-048 Reset asserted after 100 pixels are loaded -> LOAD with counter 0; a reload from pixel 0 packs correctly.
REQ-049 With DT_MEM_ERR_CHECK_EN, sti_rd high during LOAD -> err=1 persisting through DUMP; without the macro, err=0.

Source files
------------

// File: rtl/dt_mem_resp.sv
// dt_mem_resp: memory responder for a binary-image client.
//   LOAD : packs a stream of 1-bit pixels MSB-first into 16-bit source words.
//   SERVE: answers source reads (sti_*) and result reads/writes (res_*).
//   DUMP : streams every result byte in ascending address order (valid/ready).
//   FIN  : idle until reset.
// Ports:
//   clk, reset (async, active-low)
//   ld_valid/ld_pix/ld_ready/ld_done          pixel load stream and status
//   sti_rd/sti_addr/sti_di                    source word read port (1-cycle)
//   res_rd/res_wr/res_addr/res_do/res_di      result byte port (1-cycle, write-first)
//   done                                      client finished, starts the dump
//   dump_valid/dump_data/dump_last/dump_ready result dump stream
//   err                                       sticky protocol error
// Optional feature: define DT_MEM_ERR_CHECK_EN to enable protocol error
// detection on err; otherwise err is tied to 0.
module dt_mem_resp #(
  parameter int unsigned STI_DEPTH = 1024,
  parameter int unsigned RES_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic        ld_pix,
  output logic        ld_ready,
  output logic        ld_done,
  input  logic        sti_rd,
  input  logic [9:0]  sti_addr,
  output logic [15:0] sti_di,
  input  logic        res_rd,
  input  logic        res_wr,
  input  logic [13:0] res_addr,
  input  logic [7:0]  res_do,
  output logic [7:0]  res_di,
  input  logic        done,
  output logic        dump_valid,
  output logic [7:0]  dump_data,
  output logic        dump_last,
  input  logic        dump_ready,
  output logic        err
);

  localparam int unsigned PIX_W  = $clog2(STI_DEPTH * 16);
  localparam int unsigned STI_AW = $clog2(STI_DEPTH);
  localparam int unsigned RES_AW = $clog2(RES_DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DUMP  = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [14:0]         sh_q, sh_d;
  logic                ld_ready_q, ld_ready_d;
  logic                ld_done_q, ld_done_d;
  logic [15:0]         sti_di_q, sti_di_d;
  logic [7:0]          res_di_q, res_di_d;
  logic                dump_valid_q, dump_valid_d;
  logic [7:0]          dump_data_q, dump_data_d;
  logic                dump_last_q, dump_last_d;
  logic [RES_AW-1:0]   dump_addr_q, dump_addr_d;
  logic [RES_DEPTH-1:0] valid_q, valid_d;

  logic [15:0]         sti_mem [STI_DEPTH];
  logic [7:0]          res_mem [RES_DEPTH];

  logic                sti_we;
  logic                res_we;
  logic [RES_AW-1:0]   res_a;
  logic [RES_AW-1:0]   dump_rd_addr;
  logic [7:0]          dump_byte;

  assign res_a = res_addr[RES_AW-1:0];

  // Next byte the dump would present: byte 0 when starting, else the successor.
  always_comb begin
    dump_rd_addr = '0;
    if (state_q == S_DUMP) dump_rd_addr = RES_AW'(dump_addr_q + 1'b1);
    dump_byte = valid_q[dump_rd_addr] ? res_mem[dump_rd_addr] : 8'h00;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    sh_d         = sh_q;
    ld_ready_d   = ld_ready_q;
    ld_done_d    = ld_done_q;
    sti_di_d     = sti_di_q;
    res_di_d     = res_di_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_last_d  = dump_last_q;
    dump_addr_d  = dump_addr_q;
    valid_d      = valid_q;
    sti_we       = 1'b0;
    res_we       = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          sh_d      = {sh_q[13:0], ld_pix};
          pix_cnt_d = PIX_W'(pix_cnt_q + 1'b1);
          // 16th pixel of a word completes it together with the 15 shifted ones.
          if (pix_cnt_q[3:0] == 4'hF) sti_we = 1'b1;
          if (pix_cnt_q == PIX_W'(STI_DEPTH * 16 - 1)) begin
            state_d    = S_SERVE;
            ld_ready_d = 1'b0;
            ld_done_d  = 1'b1;
          end
        end
      end
      S_SERVE: begin
        if (sti_rd) sti_di_d = sti_mem[sti_addr[STI_AW-1:0]];
        if (res_wr) begin
          res_we         = 1'b1;
          valid_d[res_a] = 1'b1;
        end
        if (res_rd) begin
          if (res_wr)              res_di_d = res_do;
          else if (valid_q[res_a]) res_di_d = res_mem[res_a];
          else                     res_di_d = 8'h00;
        end
        if (done) begin
          state_d      = S_DUMP;
          dump_valid_d = 1'b1;
          dump_addr_d  = '0;
          // Forward a same-cycle write to byte 0 into the first dump beat.
          dump_data_d  = (res_wr && res_a == '0) ? res_do : dump_byte;
          dump_last_d  = (RES_DEPTH == 1);
        end
      end
      S_DUMP: begin
        if (dump_valid_q && dump_ready) begin
          if (dump_last_q) begin
            state_d      = S_FIN;
            dump_valid_d = 1'b0;
            dump_last_d  = 1'b0;
          end else begin
            dump_addr_d = dump_rd_addr;
            dump_data_d = dump_byte;
            dump_last_d = (dump_rd_addr == RES_AW'(RES_DEPTH - 1));
          end
        end
      end
      default: begin
        dump_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; the valid-map clears on reset, memories do not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      pix_cnt_q    <= '0;
      sh_q         <= '0;
      ld_ready_q   <= 1'b1;
      ld_done_q    <= 1'b0;
      sti_di_q     <= '0;
      res_di_q     <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
      dump_addr_q  <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      sh_q         <= sh_d;
      ld_ready_q   <= ld_ready_d;
      ld_done_q    <= ld_done_d;
      sti_di_q     <= sti_di_d;
      res_di_q     <= res_di_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
      dump_addr_q  <= dump_addr_d;
      valid_q      <= valid_d;
    end
  end

  // Storage arrays.
  always_ff @(posedge clk) begin
    if (sti_we) sti_mem[pix_cnt_q[PIX_W-1:4]] <= {sh_q, ld_pix};
    if (res_we) res_mem[res_a] <= res_do;
  end

`ifdef DT_MEM_ERR_CHECK_EN
  logic err_q, err_d;

  // Sticky flag for accesses the current state does not accept.
  always_comb begin
    err_d = err_q;
    if ((state_q != S_SERVE) && (sti_rd || res_rd || res_wr)) err_d = 1'b1;
    if ((state_q != S_LOAD) && ld_valid)                      err_d = 1'b1;
    if ((state_q == S_LOAD) && done)                          err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ld_ready   = ld_ready_q;
  assign ld_done    = ld_done_q;
  assign sti_di     = sti_di_q;
  assign res_di     = res_di_q;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;

endmodule
